// File: rtl/rv_mem_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 size codes, timeout counter width.
// Pure declarations; no latency or flow control of its own.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mau_state_t;

  localparam int FUNCT3_W  = 3;
  localparam int SIZE_W    = 2;
  localparam int TIMEOUT_W = 8;

  localparam logic [SIZE_W-1:0] SZ_B = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_H = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_W = 2'b10;

  // Lanes past byte 3 fall off the 4-bit shift, which is how misaligned halves get truncated.
  function automatic logic [3:0] store_strobe(input logic [SIZE_W-1:0] size, input logic [1:0] offset);
    logic [3:0] strb;
    case (size)
      SZ_B:    strb = 4'b0001 << offset;
      SZ_H:    strb = 4'b0011 << offset;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/load_data_aligner.sv
// Extracts the addressed byte/half from a bus word and sign- or zero-extends it per funct3.
// Purely combinational; no flow control.
module load_data_aligner
  import rv_mem_pkg::*;
(
  input  logic [31:0]         i_word,
  input  logic [1:0]          i_offset,
  input  logic [FUNCT3_W-1:0] i_funct3,
  output logic [31:0]         o_data
);

  logic [31:0] w_shifted;
  logic        w_signed;

  assign w_shifted = i_word >> {i_offset, 3'b000};
  assign w_signed  = ~i_funct3[2];

  always_comb begin
    o_data = i_word;
    case (i_funct3[1:0])
      SZ_B:    o_data = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    o_data = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Multicycle load/store unit: one bus transaction per request, with timeout and illegal-request faults; MISALIGN_TRAP_EN makes misaligned H/W faults.
// Latency: req_done 2 cycles after accept at best (1 for illegal); bus_valid held until bus_ready or timeout.
module memory_access_unit
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_type,
  output logic        busy,
  output logic        req_done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  mau_state_t r_state;
  mau_state_t w_next;

  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_write;
  logic [1:0]           r_offset;
  logic [FUNCT3_W-1:0]  r_funct3;
  logic                 r_fault;
  logic [31:0]          r_rdata;
  logic                 r_bus_write;
  logic [31:0]          r_bus_addr;
  logic [3:0]           r_bus_wstrb;
  logic [31:0]          r_bus_wdata;

  logic        w_accept;
  logic        w_fault_next;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_timeout;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_load;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((req_type[1:0] == SZ_H) && req_addr[0]) ||
                      ((req_type[1:0] == SZ_W) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_illegal = (req_write ? (req_type[1:0] == 2'b11)
                                : (req_type == 3'b011 || req_type == 3'b110 || req_type == 3'b111))
                     || w_misalign;

  // r_cnt holds REQ cycles already spent, so this fires on the TIMEOUT_CYCLES-th one.
  assign w_timeout = (r_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = req_wdata;
    if (req_write) begin
      w_wstrb = store_strobe(req_type[1:0], req_addr[1:0]);
      case (req_type[1:0])
        SZ_B:    w_wdata = {4{req_wdata[7:0]}};
        SZ_H:    w_wdata = {2{req_wdata[15:0]}};
        default: w_wdata = req_wdata;
      endcase
    end
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_fault_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept     = 1'b1;
          w_next       = w_illegal ? ST_DONE : ST_REQ;
          w_fault_next = w_illegal;
        end
      end
      ST_REQ: begin
        if (bus_ready) begin
          w_next = ST_DONE;
        end else if (w_timeout) begin
          w_next       = ST_DONE;
          w_fault_next = 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_offset    <= 2'b00;
      r_funct3    <= '0;
      r_fault     <= 1'b0;
      r_rdata     <= '0;
      r_bus_write <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wstrb <= 4'b0000;
      r_bus_wdata <= '0;
    end else begin
      r_fault <= w_fault_next;
      if (r_state == ST_REQ) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_accept) begin
        r_write     <= req_write;
        r_offset    <= req_addr[1:0];
        r_funct3    <= req_type;
        r_bus_write <= req_write;
        r_bus_addr  <= {req_addr[31:2], 2'b00};
        r_bus_wstrb <= w_wstrb;
        r_bus_wdata <= w_wdata;
      end
      if ((r_state == ST_REQ) && bus_ready && !r_write) begin
        r_rdata <= w_load;
      end
    end
  end

  load_data_aligner u_aligner (
    .i_word   (bus_rdata),
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .o_data   (w_load)
  );

  assign busy      = (r_state == ST_REQ) || (r_state == ST_DONE);
  assign req_done  = (r_state == ST_DONE);
  assign fault     = r_fault;
  assign rdata     = r_rdata;
  assign bus_valid = (r_state == ST_REQ);
  assign bus_write = r_bus_write;
  assign bus_addr  = r_bus_addr;
  assign bus_wstrb = r_bus_wstrb;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: loads, stores, timeout, illegal/misaligned requests, mid-transaction reset.
module tb_memory_access_unit;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_type;
  logic        busy;
  logic        req_done;
  logic [31:0] rdata;
  logic        fault;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  int          res_lat;
  logic        res_fault;
  int          res_vcyc;
  logic        res_stable;
  logic [31:0] cap_addr;
  logic [3:0]  cap_wstrb;
  logic [31:0] cap_wdata;
  logic        cap_write;

  memory_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_type  (req_type),
    .busy      (busy),
    .req_done  (req_done),
    .rdata     (rdata),
    .fault     (fault),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_write (bus_write),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // rdy_at = REQ cycle (1-based) in which bus_ready is raised; 0 = never.
  task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] t, input int rdy_at, input logic [31:0] rd);
    @(negedge clk);
    chk("idle_flags", {28'd0, busy, req_done, fault, bus_valid}, 32'd0);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = wd;
    req_type   = t;
    bus_rdata  = rd;
    res_lat    = -1;
    res_fault  = 1'b0;
    res_vcyc   = 0;
    res_stable = 1'b1;
    for (int c = 1; c <= 400 && res_lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0;
        req_type  = 3'b111;
      end
      if (req_done) begin
        res_lat   = c;
        res_fault = fault;
      end
      if (bus_valid) begin
        if (res_vcyc == 0) begin
          cap_addr  = bus_addr;
          cap_wstrb = bus_wstrb;
          cap_wdata = bus_wdata;
          cap_write = bus_write;
        end else if (bus_addr !== cap_addr || bus_wstrb !== cap_wstrb ||
                     bus_wdata !== cap_wdata || bus_write !== cap_write) begin
          res_stable = 1'b0;
        end
        res_vcyc++;
      end
      bus_ready = bus_valid && (res_vcyc == rdy_at);
    end
    bus_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_type  = '0;
    bus_ready = 1'b0;
    bus_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_flags", {26'd0, busy, req_done, fault, bus_valid, bus_write, 1'b0}, 32'd0);
    chk("rst_wstrb", {28'd0, bus_wstrb}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    reset = 1'b0;

    // LW 0x100, ready in first REQ cycle
    run_req(1'b0, 32'h100, 32'h0, 3'b010, 1, 32'hDEADBEEF);
    chk("lw_lat", res_lat, 2);
    chk("lw_fault", {31'd0, res_fault}, 0);
    chk("lw_addr", cap_addr, 32'h100);
    chk("lw_wstrb", {28'd0, cap_wstrb}, 0);
    chk("lw_rdata", rdata, 32'hDEADBEEF);

    run_req(1'b0, 32'h103, 32'h0, 3'b000, 1, 32'h80FF_0000);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    run_req(1'b0, 32'h103, 32'h0, 3'b100, 1, 32'h80FF_0000);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    run_req(1'b0, 32'h102, 32'h0, 3'b001, 1, 32'h80FF_0000);
    chk("lh_rdata", rdata, 32'hFFFF_80FF);
    run_req(1'b0, 32'h102, 32'h0, 3'b101, 1, 32'h80FF_0000);
    chk("lhu_rdata", rdata, 32'h0000_80FF);

    // SH 0x202
    run_req(1'b1, 32'h202, 32'h1234_ABCD, 3'b001, 1, 32'h5555_5555);
    chk("sh_wstrb", {28'd0, cap_wstrb}, 32'hC);
    chk("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("sh_write", {31'd0, cap_write}, 1);
    chk("sh_addr", cap_addr, 32'h200);
    chk("sh_rdata_kept", rdata, 32'h0000_80FF);

    // SB with bus_ready in third REQ cycle: outputs must stay stable
    run_req(1'b1, 32'h201, 32'h0000_0055, 3'b000, 3, 32'h0);
    chk("sb_lat", res_lat, 4);
    chk("sb_vcyc", res_vcyc, 3);
    chk("sb_stable", {31'd0, res_stable}, 1);
    chk("sb_wstrb", {28'd0, cap_wstrb}, 32'h2);
    chk("sb_wdata", cap_wdata, 32'h5555_5555);

    run_req(1'b1, 32'h300, 32'h0BAD_F00D, 3'b010, 1, 32'h0);
    chk("sw_wstrb", {28'd0, cap_wstrb}, 32'hF);
    chk("sw_wdata", cap_wdata, 32'h0BAD_F00D);

    // Timeout
    run_req(1'b0, 32'h104, 32'h0, 3'b010, 0, 32'h1111_1111);
    chk("to_lat", res_lat, TO + 1);
    chk("to_fault", {31'd0, res_fault}, 1);
    chk("to_vcyc", res_vcyc, TO);
    chk("to_rdata_kept", rdata, 32'h0000_80FF);

    // bus_ready on the timeout cycle wins
    run_req(1'b0, 32'h108, 32'h0, 3'b010, TO, 32'hCAFE_F00D);
    chk("prio_lat", res_lat, TO + 1);
    chk("prio_fault", {31'd0, res_fault}, 0);
    chk("prio_rdata", rdata, 32'hCAFE_F00D);

    run_req(1'b0, 32'h100, 32'h0, 3'b011, 1, 32'h0);
    chk("ill_ld_lat", res_lat, 1);
    chk("ill_ld_fault", {31'd0, res_fault}, 1);
    chk("ill_ld_vcyc", res_vcyc, 0);
    chk("ill_ld_rdata", rdata, 32'hCAFE_F00D);

    run_req(1'b1, 32'h100, 32'h0, 3'b111, 1, 32'h0);
    chk("ill_st_fault", {31'd0, res_fault}, 1);
    chk("ill_st_vcyc", res_vcyc, 0);

    // Misaligned LW 0x102
    run_req(1'b0, 32'h102, 32'h0, 3'b010, 1, 32'h1122_3344);
`ifdef MISALIGN_TRAP_EN
    chk("mis_fault", {31'd0, res_fault}, 1);
    chk("mis_vcyc", res_vcyc, 0);
    chk("mis_rdata", rdata, 32'hCAFE_F00D);
`else
    chk("mis_fault", {31'd0, res_fault}, 0);
    chk("mis_addr", cap_addr, 32'h100);
    chk("mis_rdata", rdata, 32'h1122_3344);
`endif

    // Reset in the third REQ cycle
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h400;
    req_type  = 3'b010;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_valid", {31'd0, bus_valid}, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_flags", {28'd0, busy, req_done, fault, bus_valid}, 0);
    chk("mid_rst_addr", bus_addr, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    run_req(1'b0, 32'h100, 32'h0, 3'b010, 1, 32'hA5A5_5A5A);
    chk("post_lat", res_lat, 2);
    chk("post_fault", {31'd0, res_fault}, 0);
    chk("post_rdata", rdata, 32'hA5A5_5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_access_unit.md
MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles bus_valid stays asserted without bus_ready before a timeout fault.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1: access request from the multicycle controller.
REQ-005 SHALL have port req_write, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_addr, input, 32: byte address (execute result).
REQ-007 SHALL have port req_wdata, input, 32: store source data, unshifted.
REQ-008 SHALL have port req_type, input, 3: funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU); stores use [1:0] only.
REQ-009 SHALL have port busy, output, 1: high in REQ and DONE states.
REQ-010 SHALL have port req_done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 32: aligned and extended load data.
REQ-012 SHALL have port fault, output, 1: one-cycle pulse, coincident with req_done, on timeout or illegal or misaligned request.
REQ-013 SHALL have port bus_valid, output, 1: bus request.
REQ-014 SHALL have port bus_ready, input, 1: bus accept and completion.
REQ-015 SHALL have port bus_write, output, 1: bus write strobe.
REQ-016 SHALL have port bus_addr, output, 32: word address, bits [1:0] always 0.
REQ-017 SHALL have port bus_wstrb, output, 4: byte lane enables.
REQ-018 SHALL have port bus_wdata, output, 32: lane-shifted store data.
REQ-019 SHALL have port bus_rdata, input, 32: read word, sampled on the bus_ready cycle.

Function
REQ-020 SHALL use a three-state FSM: IDLE -> REQ on req_valid; REQ -> DONE on bus_ready or timeout; DONE -> IDLE unconditionally.
REQ-021 SHALL latch req_write, req_addr, req_wdata and req_type on the IDLE cycle that accepts the request; later input changes SHALL be ignored until IDLE.
REQ-022 SHALL ignore req_valid outside IDLE.
REQ-023 SHALL assert bus_valid and hold all bus_* outputs stable for every cycle in REQ, and keep bus_valid low in all other states.
REQ-024 SHALL set bus_wstrb for stores as follows: B = 0001 << addr[1:0]; H = 0011 << addr[1:0]; W = 1111. For loads bus_wstrb SHALL be 0000.
REQ-025 SHALL form bus_wdata by replicating the byte or half across lanes.
REQ-026 SHALL register the load result on the bus_ready cycle as follows: select byte or half by addr[1:0]; sign-extend for B and H; zero-extend for BU and HU.
REQ-027 SHALL hold rdata until the next load completes, and leave it unchanged by stores and faults.
REQ-028 SHALL assert req_done in DONE; minimum latency from accept to req_done SHALL be 2 cycles (bus_ready in the first REQ cycle).
REQ-029 SHALL count REQ cycles with an 8-bit counter; when the count reaches TIMEOUT_CYCLES without bus_ready, it SHALL go to DONE with fault=1.
REQ-030 SHALL treat req_type 011, 110 and 111 (load), or req_type[1:0]=11 (store), as illegal: no bus cycle, IDLE -> DONE directly, fault=1.
REQ-031 SHALL, when bus_ready and the timeout occur in the same cycle, give bus_ready priority: normal completion, no fault.

Reset
REQ-032 SHALL, on reset (including mid-transaction), enter IDLE the next cycle, clear the counter, drive busy, req_done, fault, bus_valid and bus_write to 0, bus_wstrb to 0000, and rdata, bus_addr and bus_wdata to 0.

Configuration
REQ-033 SHALL, when MISALIGN_TRAP_EN is defined, treat a halfword access with addr[0]=1 or a word access with addr[1:0]!=00 as illegal, with the REQ-030 behaviour.
REQ-034 SHALL, when MISALIGN_TRAP_EN is undefined, issue misaligned accesses as-is: truncate to the containing word, mask out lanes beyond byte 3, and raise no fault.

Structure
REQ-035 SHALL place the state enum, the funct3 width constants and TIMEOUT width in shared package rv_mem_pkg.
REQ-036 SHALL implement extraction and extension in one combinational sub-module, load_data_aligner.

Verification
REQ-037 SHALL cover: LW addr 0x100, bus_ready in first REQ cycle, bus_rdata 0xDEADBEEF -> bus_addr 0x100, req_done 2 cycles after accept, rdata 0xDEADBEEF.
REQ-038 SHALL cover: LB addr 0x103, bus_rdata 0x80FF_0000 -> rdata 0xFFFFFF80; the same access as LBU -> rdata 0x00000080.
REQ-039 SHALL cover: SH addr 0x202, wdata 0x1234ABCD -> bus_wstrb 1100, bus_wdata 0xABCDABCD, bus_write 1.
REQ-040 SHALL cover: LW with bus_ready held low -> fault and req_done together TIMEOUT_CYCLES+1 cycles after accept, and rdata unchanged.
REQ-041 SHALL cover: LW addr 0x102 -> fault and no bus_valid with MISALIGN_TRAP_EN; a normal bus cycle at 0x100 without it.
REQ-042 SHALL cover: reset asserted in the third REQ cycle -> bus_valid 0 next cycle; a following request completes normally.
